// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-load, LSB-first serial pattern source with loop and abort
module pattern_serializer #(
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pattern,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     abort,
  output logic                     sig_out,
  output logic                     valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sig_q, sig_d;
  logic               done_q, done_d;

  // Next state and the outputs that will be shown during the following cycle.
  // Outputs are computed from the next state so they come straight off flops.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    done_d  = done_q;
    if (ena) begin
      idx_d  = '0;
      sig_d  = 1'b0;
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            pat_d   = pattern;
            state_d = start ? SHIFT : READY;
          end
        end
        READY: begin
          if (load) begin
            pat_d = pattern;
          end
          if (start) begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_d = READY;
          end else if (idx_q == LAST_IDX) begin
            // Looping restarts at bit 0 (idx_d default) with no gap.
            if (!loop) begin
              state_d = READY;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d == SHIFT) begin
        sig_d  = pat_d[idx_d];
        done_d = (idx_d == LAST_IDX);
      end
    end
  end

  // State, shadow pattern and output registers; ena low holds everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  assign sig_out = sig_q;
  assign valid   = (state_q == SHIFT);
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule
